// File: rtl/sram_byte_bridge_pkg.sv
// Shared definitions for the 8-bit CPU bus to 16-bit asynchronous SRAM bridge.
// Contents:
//   state_t     - controller states
//   WAIT_CNT_W  - width of the wait-state down-counter (up to 15 extra cycles)
//   sel_byte()  - picks the CPU byte out of a 16-bit SRAM word
package sram_byte_bridge_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    // Byte address bit 0 selects the lane: 0 -> dq[7:0] (LB), 1 -> dq[15:8] (UB).
    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram_byte_bridge.sv
// sram_byte_bridge
// Memory-side responder for the 8-bit CPU bus. Each byte request is turned into
// a timed access on a 16-bit asynchronous SRAM using the UB/LB byte lanes.
// WAIT_STATES extra cycles are held in the read strobe and in the write pulse.
//
// Ports:
//   clock, reset_n           system clock, async active-low reset
//   req, address, o_data, we CPU request (accepted only while busy=0)
//   i_data, ready, busy      read data, 1-cycle completion pulse, busy flag
//   sram_addr                SRAM word address (address[ADDR_W-1:1])
//   sram_dq_i/o, sram_dq_oe  SRAM data bus halves and tri-state enable
//   sram_ce_n/oe_n/we_n      active-low SRAM strobes
//   sram_ub_n/lb_n           active-low byte lane enables
//
// Build option: define SRAM_BYTE_BRIDGE_WORDBUF_EN to keep the last word read
// from SRAM in a one-word buffer; reads that hit it skip the SRAM access.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for req; ready pulses here on the cycle after a completion
// RD       | ce_n/oe_n low, counting down wait states (or a buffer hit)
// WR_SETUP | address/data on the bus, we_n still high
// WR_PULSE | we_n low for WAIT_STATES+1 cycles
// WR_HOLD  | we_n high again, data and lane still driven for hold time
module sram_byte_bridge
    import sram_byte_bridge_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        o_data,
    input  logic              we,
    output logic [7:0]        i_data,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-2:0] sram_addr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  lane_hi;

`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
    logic [15:0]       buf_word;
    logic [ADDR_W-2:0] buf_waddr;
    logic              buf_valid;
    logic              rd_hit;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lane_hi    <= 1'b0;
            i_data     <= 8'h00;
            ready      <= 1'b0;
            busy       <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
            buf_word   <= 16'h0000;
            buf_waddr  <= '0;
            buf_valid  <= 1'b0;
            rd_hit     <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        busy      <= 1'b1;
                        sram_addr <= address[ADDR_W-1:1];
                        lane_hi   <= address[0];
                        if (we) begin
                            sram_dq_o  <= {o_data, o_data};
                            sram_dq_oe <= 1'b1;
                            sram_ce_n  <= 1'b0;
                            sram_ub_n  <= ~address[0];
                            sram_lb_n  <= address[0];
                            state      <= WR_SETUP;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= RD;
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
                            if (buf_valid && buf_waddr == address[ADDR_W-1:1])
                                rd_hit <= 1'b1;
                            else
`endif
                            begin
                                sram_ce_n <= 1'b0;
                                sram_oe_n <= 1'b0;
                                sram_ub_n <= ~address[0];
                                sram_lb_n <= address[0];
                            end
                        end
                    end
                end

                RD: begin
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
                    if (rd_hit) begin
                        i_data <= sel_byte(buf_word, lane_hi);
                        rd_hit <= 1'b0;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else
`endif
                    if (wait_cnt == '0) begin
                        i_data    <= sel_byte(sram_dq_i, lane_hi);
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        state     <= IDLE;
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
                        buf_word  <= sram_dq_i;
                        buf_waddr <= sram_addr;
                        buf_valid <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= WAIT_INIT;
                    state     <= WR_PULSE;
                end

                WR_PULSE: begin
                    if (wait_cnt == '0) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                WR_HOLD: begin
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
                    // Keep the buffered word coherent with the byte just written.
                    if (buf_valid && buf_waddr == sram_addr) begin
                        if (lane_hi)
                            buf_word[15:8] <= sram_dq_o[15:8];
                        else
                            buf_word[7:0]  <= sram_dq_o[7:0];
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_byte_bridge.sv
module tb_sram_byte_bridge;

    localparam int WS = 1;

    logic        clock;
    logic        reset_n;
    logic        req;
    logic [19:0] address;
    logic [7:0]  o_data;
    logic        we;
    logic [7:0]  i_data;
    logic        ready;
    logic        busy;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_byte_bridge #(.ADDR_W(20), .WAIT_STATES(WS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .address    (address),
        .o_data     (o_data),
        .we         (we),
        .i_data     (i_data),
        .ready      (ready),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural asynchronous SRAM: 256 words, read while ce/oe low, write on we_n rising.
    logic [15:0] sram_mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'($urandom);
        sram_mem[8] = 16'hBEEF;
        forever begin
            @(posedge sram_we_n);
            if (reset_n === 1'b1 && sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) begin
                if (sram_ub_n === 1'b0) sram_mem[sram_addr[7:0]][15:8] = sram_dq_o[15:8];
                if (sram_lb_n === 1'b0) sram_mem[sram_addr[7:0]][7:0]  = sram_dq_o[7:0];
            end
        end
    end

    always_comb begin
        sram_dq_i = 16'hDEAD;
        if (sram_ce_n == 1'b0 && sram_oe_n == 1'b0) sram_dq_i = sram_mem[sram_addr[7:0]];
    end

    // Bus monitor sampled on the falling clock edge.
    int          rd_pulses, we_pulses, we_len_cur, last_we_len;
    logic        prev_oe_n;
    logic [18:0] last_rd_addr, last_we_addr;
    logic        last_rd_ub, last_rd_lb, last_we_ub, last_we_lb;
    logic [15:0] last_we_dq;
    bit          overlap_seen;

    initial begin
        rd_pulses = 0; we_pulses = 0; we_len_cur = 0; last_we_len = 0;
        prev_oe_n = 1'b1; overlap_seen = 0;
        forever begin
            @(negedge clock);
            if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) overlap_seen = 1;
            if (sram_oe_n === 1'b0 && prev_oe_n === 1'b1) begin
                rd_pulses++;
                last_rd_addr = sram_addr;
                last_rd_ub   = sram_ub_n;
                last_rd_lb   = sram_lb_n;
            end
            prev_oe_n = sram_oe_n;
            if (sram_we_n === 1'b0) begin
                we_len_cur++;
                last_we_addr = sram_addr;
                last_we_dq   = sram_dq_o;
                last_we_ub   = sram_ub_n;
                last_we_lb   = sram_lb_n;
            end else if (we_len_cur > 0) begin
                last_we_len = we_len_cur;
                we_len_cur  = 0;
                we_pulses++;
            end
        end
    end

    // Reference model: byte-addressed memory plus the one-word read buffer rule.
    logic [7:0]  ref_mem [0:511];
    logic [7:0]  last_rd_val;
    bit          ref_buf_valid;
    logic [18:0] ref_buf_waddr;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit model_hit(input logic [19:0] a);
`ifdef SRAM_BYTE_BRIDGE_WORDBUF_EN
        return ref_buf_valid && (ref_buf_waddr == a[19:1]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input string tag, input bit w, input logic [19:0] a, input logic [7:0] d);
        int lat, rd0, we0, exp_lat;
        bit hit;
        hit     = !w && model_hit(a);
        exp_lat = w ? WS + 3 : (hit ? 1 : WS + 1);
        rd0 = rd_pulses;
        we0 = we_pulses;
        @(negedge clock);
        req = 1'b1; we = w; address = a; o_data = d;
        @(posedge clock); #1;
        req = 1'b0; we = 1'b0;
        chk({tag, " busy_set"}, busy, 1);
        lat = 0;
        while (ready !== 1'b1 && lat < 64) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_clr"}, busy, 0);
        if (w) begin
            ref_mem[a[8:0]] = d;
            chk({tag, " we_pulses"}, we_pulses - we0, 1);
            chk({tag, " i_data_hold"}, i_data, last_rd_val);
        end else begin
            chk({tag, " rdata"}, i_data, ref_mem[a[8:0]]);
            chk({tag, " rd_pulses"}, rd_pulses - rd0, hit ? 0 : 1);
            if (!hit) begin
                ref_buf_valid = 1;
                ref_buf_waddr = a[19:1];
            end
            last_rd_val = ref_mem[a[8:0]];
        end
    endtask

    initial begin
        int          n, rd0, we0;
        bit          w;
        logic [19:0] a;

        req = 1'b0; we = 1'b0; address = '0; o_data = '0;
        reset_n = 1'b1;
        ref_buf_valid = 0; ref_buf_waddr = '0; last_rd_val = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[2*i]   = sram_mem[i][7:0];
            ref_mem[2*i+1] = sram_mem[i][15:8];
        end
        chk("rst0 ce_n", sram_ce_n, 1);
        chk("rst0 we_n", sram_we_n, 1);
        chk("rst0 ready", ready, 0);
        chk("rst0 busy", busy, 0);
        chk("rst0 i_data", i_data, 0);
        chk("rst0 dq_oe", sram_dq_oe, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;

        // Even address read: low lane
        do_op("rd_even", 0, 20'h00010, 8'h00);
        chk("rd_even lb_n", last_rd_lb, 0);
        chk("rd_even ub_n", last_rd_ub, 1);
        chk("rd_even addr", last_rd_addr, 19'h00008);
        chk("rd_even value", i_data, 8'hEF);

        // Odd address read of the same word (buffer hit when the word buffer is built in)
        chk("b2b ready_at_req", ready, 1);
        do_op("rd_odd", 0, 20'h00011, 8'h00);
        chk("rd_odd value", i_data, 8'hBE);
        if (!ref_buf_valid || ref_buf_waddr != 19'h00008 || !model_hit(20'h00011))
            chk("rd_odd ub_n", last_rd_ub, 0);

        // Write to odd address: upper lane, replicated data, timed we_n pulse
        do_op("wr_odd", 1, 20'h00021, 8'h5A);
        chk("wr dq_o", last_we_dq, 16'h5A5A);
        chk("wr ub_n", last_we_ub, 0);
        chk("wr lb_n", last_we_lb, 1);
        chk("wr addr", last_we_addr, 19'h00010);
        chk("wr we_len", last_we_len, WS + 1);
        do_op("wr_rdback", 0, 20'h00021, 8'h00);
        chk("wr_rdback value", i_data, 8'h5A);

        // Buffer-coherence sequence (plain SRAM accesses without the word buffer)
        do_op("buf_rd0", 0, 20'h00010, 8'h00);
        do_op("buf_rd1", 0, 20'h00011, 8'h00);
        do_op("buf_wr", 1, 20'h00011, 8'h77);
        do_op("buf_rdback", 0, 20'h00011, 8'h00);
        chk("buf_rdback value", i_data, 8'h77);

        // req while busy is ignored
        repeat (2) @(posedge clock);
        rd0 = rd_pulses; we0 = we_pulses;
        @(negedge clock); req = 1'b1; we = 1'b0; address = 20'h00040;
        @(negedge clock); req = 1'b1; we = 1'b1; address = 20'h00042; o_data = 8'hAA;
        chk("busy_rule busy", busy, 1);
        @(negedge clock); req = 1'b0; we = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 64) begin @(negedge clock); n++; end
        chk("busy_rule completed", ready, 1);
        chk("busy_rule rdata", i_data, ref_mem[9'h040]);
        last_rd_val = ref_mem[9'h040];
        ref_buf_valid = 1; ref_buf_waddr = 19'h00020;
        repeat (6) @(negedge clock);
        chk("busy_rule rd_pulses", rd_pulses - rd0, 1);
        chk("busy_rule we_pulses", we_pulses - we0, 0);
        chk("busy_rule idle", busy, 0);
        do_op("busy_rule rd42", 0, 20'h00042, 8'h00);

        // Random mix against the reference model
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom);
            a = 20'($urandom_range(0, 511));
            do_op(w ? "rnd_wr" : "rnd_rd", w, a, 8'($urandom));
        end

        // Async reset in the middle of a write pulse
        @(negedge clock); req = 1'b1; we = 1'b1; address = 20'h001F0; o_data = 8'hC3;
        @(posedge clock); #1; req = 1'b0; we = 1'b0;
        n = 0;
        while (sram_we_n !== 1'b0 && n < 16) begin @(posedge clock); #1; n++; end
        chk("rst_mid we_n_low", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid we_n", sram_we_n, 1);
        chk("rst_mid dq_oe", sram_dq_oe, 0);
        chk("rst_mid ce_n", sram_ce_n, 1);
        chk("rst_mid oe_n", sram_oe_n, 1);
        chk("rst_mid ub_n", sram_ub_n, 1);
        chk("rst_mid lb_n", sram_lb_n, 1);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid ready", ready, 0);
        chk("rst_mid i_data", i_data, 0);
        chk("rst_mid sram_addr", sram_addr, 0);
        chk("rst_mid dq_o", sram_dq_o, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        ref_buf_valid = 0;
        last_rd_val = 8'h00;
        do_op("post_rst rd", 0, 20'h00010, 8'h00);

        chk("oe_dq_overlap", overlap_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_byte_bridge.md
Name: sram_byte_bridge

Overview:
- Memory-side responder for the 8-bit CPU bus (address / o_data / we in, i_data out).
- Serves byte requests from a 16-bit asynchronous external SRAM with UB/LB byte lanes.
- Replaces the ideal 1-cycle memory model with a real timed controller.
- Programmable wait states; a ready pulse tells the CPU when a request has completed.

Parameters:
- ADDR_W, 20, CPU byte-address width; SRAM word address is ADDR_W-1 bits.
- WAIT_STATES, 1, extra cycles held in the SRAM read strobe and in the write pulse (0..15).

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  CPU request strobe; accepted only when busy=0.
- address  in  ADDR_W  CPU byte address.
- o_data  in  8  CPU write data.
- we  in  1  1 = write, 0 = read; sampled with req.
- i_data  out  8  read data to CPU.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from the edge accepting req until the edge that asserts ready.
- sram_addr  out  ADDR_W-1  word address.
- sram_dq_i  in  16  SRAM data in.
- sram_dq_o  out  16  SRAM data out.
- sram_dq_oe  out  1  tri-state enable for sram_dq_o.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, i_data=0, ready=0, busy=0, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - All sram_*_n=1, asserted immediately without waiting for a clock.
  - Reset during a write aborts it; the SRAM contents for that write are undefined.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are registered.
- IDLE:
  - ready=0 except on the cycle after a completion.
  - On req=1, latch address/o_data/we and set busy=1.
  - sram_addr = address[ADDR_W-1:1].
  - Byte lane: address[0]=0 drives lb_n=0 (dq[7:0]); address[0]=1 drives ub_n=0 (dq[15:8]).
  - sram_ce_n=0.
  - we=0 → RD with oe_n=0, wait counter = WAIT_STATES.
  - we=1 → WR_SETUP with dq_o={o_data,o_data} and dq_oe=1.
- RD:
  - Counter decrements once per cycle.
  - At the edge where counter==0: i_data <= selected byte of sram_dq_i; ready<=1, busy<=0, ce_n/oe_n/ub_n/lb_n<=1; → IDLE.
  - Read latency: ready is high WAIT_STATES+1 cycles after the edge that sampled req.
- WR_SETUP: one cycle with we_n=1 (address/data setup), then we_n<=0, counter=WAIT_STATES → WR_PULSE.
- WR_PULSE: we_n held low for WAIT_STATES+1 cycles, then we_n<=1 → WR_HOLD.
- WR_HOLD:
  - One cycle; dq_oe and the byte lane are still driven (data hold).
  - Then dq_oe<=0, controls<=1, ready<=1, busy<=0 → IDLE.
  - Write latency: ready WAIT_STATES+3 cycles after req.
- i_data holds its last read value through writes and idle cycles; it changes only on read completion.
- req while busy=1 is ignored (not queued). The CPU must wait for ready.
- req in the same cycle that ready is high is accepted, giving back-to-back operation.
- dq_oe and oe_n are never both active. oe_n is forced to 1 in all write states.
- Address wrap: no special case; address bits above ADDR_W do not exist.

Optional Feature:
- Macro: SRAM_BYTE_BRIDGE_WORDBUF_EN.
- With the macro defined, keep a 16-bit buffer holding the word of the last SRAM read, plus its word address and a valid bit:
  - A read hitting the buffer (valid=1, word address equal) performs no SRAM access. The bridge returns the selected byte with ready one cycle after req; busy stays high for that one cycle.
  - A write to the buffered word updates the matching buffer byte.
  - Reset clears valid.
- Without the macro: no buffer; every read goes to SRAM with the latency above.

Decomposition:
- Package sram_byte_bridge_pkg holds:
  - the state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - WAIT_CNT_W = 4;
  - the byte-lane select helper function.
- No sub-module; single module. The word buffer stays inline under the macro.

Test Plan:
- Reset: hold reset_n=0 mid-write (we_n=0) → sram_we_n=1 and dq_oe=0 immediately; all outputs at reset values.
- Read even address, WAIT_STATES=1: address=20'h00010, SRAM word 16'hBEEF → lb_n=0, ready 2 cycles after req, i_data=8'hEF.
- Read odd address: address=20'h00011, same word → ub_n=0, i_data=8'hBE.
- Write, WAIT_STATES=1: o_data=8'h5A at 20'h00021 → dq_o=16'h5A5A, ub_n=0, we_n low for exactly 2 cycles, ready 4 cycles after req; readback returns 8'h5A.
- Busy rule: second req one cycle after the first → ignored, exactly one SRAM access. req in the same cycle as ready → accepted, back-to-back accesses.
- WORDBUF_EN: read 20'h00010, then 20'h00011 → second ready 1 cycle after req with no oe_n pulse. After a write of 8'h77 to 20'h00011, a read of 20'h00011 returns 8'h77 from the buffer.
